count_8bit_timer_ctrl: RTL

- Sequencing controller wrapped around the 8-bit up-counter datapath; it turns the free-running counter into a programmable interval timer.
- Captures a terminal value and mode on START, then advances the count once per prescaled tick.
- Supports pause (HOLD), abort (STOP), one-shot and auto-reload operation.
- Emits a one-cycle DONE pulse at terminal count; a sticky ERR flags START requests that arrive while busy.

---
 rtl/count_8bit_timer_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/count_8bit_timer_ctrl.sv
// Programmable interval timer: an up-counter advanced once per prescaled tick,
// with one-shot / auto-reload modes, pause, abort and a sticky busy-START error.
module count_8bit_timer_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             STOP,
  input  logic             HOLD,
  input  logic             RELOAD_MODE,
  input  logic [WIDTH-1:0] TERM_VAL,
  output logic [WIDTH-1:0] COUNT_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [1:0]       STATE
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_DONE   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             active;
  logic [WIDTH-1:0] count_inc;

  assign active    = (state_q == S_RUN) || (state_q == S_PAUSED);
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if (STOP) begin
      state_d = S_IDLE;
      count_d = '0;
      presc_d = '0;
      busy_d  = 1'b0;
      err_d   = 1'b0;
    end else if (START && !active) begin
      term_d  = TERM_VAL;
      mode_d  = RELOAD_MODE;
      count_d = '0;
      presc_d = '0;
      busy_d  = 1'b1;
      state_d = S_RUN;
    end else if (active) begin
      // A START while busy is only flagged; the timer keeps running this edge.
      if (START) err_d = 1'b1;
      if (HOLD) begin
        state_d = S_PAUSED;
      end else begin
        state_d = S_RUN;
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          // term_q == 0 matches the wrap from all-ones back to zero.
          if (count_inc == term_q) begin
            done_d = 1'b1;
            if (mode_q) begin
              count_d = '0;
            end else begin
              count_d = term_q;
              state_d = S_DONE;
              busy_d  = 1'b0;
            end
          end else begin
            count_d = count_inc;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      count_q <= '0;
      term_q  <= '0;
      presc_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign COUNT_OUT = count_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign STATE     = state_q;

endmodule
